// File: rtl/reg_file_mport.sv
// Multi-port register file: NREAD async read ports, two prioritised write ports,
// post-reset hardware clear. Define REG_FILE_MPORT_BYPASS_EN for write-to-read forwarding.
module reg_file_mport #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic                     we0,
  input  logic [AWIDTH-1:0]        waddr0,
  input  logic [DWIDTH-1:0]        wdata0,
  input  logic                     we1,
  input  logic [AWIDTH-1:0]        waddr1,
  input  logic [DWIDTH-1:0]        wdata1,
  input  logic [NREAD*AWIDTH-1:0]  raddr,
  output logic [NREAD*DWIDTH-1:0]  rdata
);

  localparam logic [0:0]      ST_CLEAR = 1'b0;
  localparam logic [0:0]      ST_IDLE  = 1'b1;
  localparam logic [AWIDTH:0] DEPTH_W  = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] LAST_W   = DEPTH_W - {{AWIDTH{1'b0}}, 1'b1};
  localparam logic            ZERO_EN  = (ZERO_REG != 0);

  logic [0:0]        state_r;
  logic [AWIDTH:0]   ptr_r;
  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic              busy_s;
  logic              wv0_s;
  logic              wv1_s;

  // An address is storable/readable only if in range and not the hardwired zero entry
  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_EN && (a == {AWIDTH{1'b0}}));
  endfunction

  assign busy_s = (state_r == ST_CLEAR);
  assign busy   = busy_s;
  assign wv0_s  = we0 && !busy_s && addr_ok(waddr0);
  assign wv1_s  = we1 && !busy_s && addr_ok(waddr1);

  // Clear sequencer and write ports; port 1 wins an address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {(AWIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          mem_r[ptr_r[AWIDTH-1:0]] <= {DWIDTH{1'b0}};
          ptr_r <= ptr_r + {{AWIDTH{1'b0}}, 1'b1};
          if (ptr_r == LAST_W) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (wv0_s && !(wv1_s && (waddr0 == waddr1))) begin
            mem_r[waddr0] <= wdata0;
          end
          if (wv1_s) begin
            mem_r[waddr1] <= wdata1;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AWIDTH-1:0] ra_s;
    logic [DWIDTH-1:0] rd_s;

    assign ra_s = raddr[k*AWIDTH +: AWIDTH];

    // Combinational read; blocked reads return zero, dropped writes are never forwarded
    always_comb begin
      rd_s = {DWIDTH{1'b0}};
      if (busy_s || !addr_ok(ra_s)) begin
        rd_s = {DWIDTH{1'b0}};
`ifdef REG_FILE_MPORT_BYPASS_EN
      end else if (wv1_s && (waddr1 == ra_s)) begin
        rd_s = wdata1;
      end else if (wv0_s && (waddr0 == ra_s)) begin
        rd_s = wdata0;
`endif
      end else begin
        rd_s = mem_r[ra_s];
      end
    end

    assign rdata[k*DWIDTH +: DWIDTH] = rd_s;
  end

endmodule

// File: tb/tb_reg_file_mport.sv
// Randomised + directed bench for reg_file_mport against an array-based reference model.
module tb_reg_file_mport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 24;
  localparam int NR    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;

  logic [DW-1:0] model [DEPTH];
  int clear_cnt = DEPTH;
  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  reg_file_mport #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .NREAD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_ok(input logic we, input logic [AW-1:0] a);
    return we && (clear_cnt == 0) && (int'(a) < DEPTH) && (a != 5'd0);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (clear_cnt != 0 || int'(a) >= DEPTH || a == 5'd0) return 32'd0;
`ifdef REG_FILE_MPORT_BYPASS_EN
    if (wr_ok(we1, waddr1) && waddr1 == a) return wdata1;
    if (wr_ok(we0, waddr0) && waddr0 == a) return wdata0;
`endif
    return model[a];
  endfunction

  // Check outputs for current inputs, advance the model, then take one clock edge
  task automatic cycle();
    bit v0, v1;
    #1;
    check_eq("busy", {31'd0, busy}, {31'd0, clear_cnt != 0});
    for (int k = 0; k < NR; k++)
      check_eq($sformatf("rdata%0d@%0d", k, raddr[k*AW +: AW]),
               rdata[k*DW +: DW], exp_read(raddr[k*AW +: AW]));
    v0 = wr_ok(we0, waddr0);
    v1 = wr_ok(we1, waddr1);
    if (rst) begin
      clear_cnt = DEPTH;
    end else if (clear_cnt > 0) begin
      model[DEPTH - clear_cnt] = 32'd0;
      clear_cnt--;
    end else begin
      if (v0) model[waddr0] = wdata0;
      if (v1) model[waddr1] = wdata1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    raddr = {a3, a2, a1, a0};
  endtask

  // Count busy cycles after rst falls; bounded so a stuck clear still ends
  task automatic run_clear(input string tag);
    n = 0;
    while (busy && n < DEPTH + 4) begin
      cycle();
      n++;
    end
    check_eq(tag, n, DEPTH);
  endtask

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0;
    waddr0 = 5'd0; waddr1 = 5'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    raddr = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    cycle();

    // Initial clear with a pending write that must wait for busy to fall
    rst = 1'b0; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAA;
    set_raddr(5'd3, 5'd0, 5'd23, 5'd30);
    run_clear("clear_len_initial");
    cycle();
    we0 = 1'b0;
    cycle();

    // Preload nonzero contents
    repeat (120) begin
      we0 = 1'b1; waddr0 = 5'($urandom_range(1, DEPTH-1)); wdata0 = $urandom | 32'h1;
      we1 = 1'($urandom); waddr1 = 5'($urandom_range(1, DEPTH-1)); wdata1 = $urandom | 32'h1;
      set_raddr(5'($urandom_range(0, 31)), waddr0, waddr1, 5'($urandom_range(0, 31)));
      cycle();
    end

    // One-cycle reset pulse wipes everything; write to 3 lands on first idle edge
    we1 = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAA;
    set_raddr(5'd3, 5'd5, 5'd9, 5'd23);
    run_clear("clear_len_after_preload");
    cycle();
    we0 = 1'b0;
    for (int b = 0; b < 32; b += 4) begin
      set_raddr(5'(b), 5'(b+1), 5'(b+2), 5'(b+3));
      cycle();
    end

    // Dual-write conflict, then distinct addresses
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7; wdata0 = 32'h11; wdata1 = 32'h22;
    set_raddr(5'd7, 5'd7, 5'd5, 5'd6);
    cycle();
    waddr0 = 5'd5; waddr1 = 5'd6; wdata0 = 32'h55; wdata1 = 32'h66;
    cycle();
    we0 = 1'b0; we1 = 1'b0;
    cycle();
    check_eq("conflict_mem7", model[7], 32'h22);

    // Zero register on both ports, all read ports on entry 0
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd0; waddr1 = 5'd0;
    wdata0 = 32'hDEADBEEF; wdata1 = 32'hDEADBEEF;
    set_raddr(5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    we0 = 1'b0; we1 = 1'b0;
    cycle();

    // Bypass / no-bypass visibility on entry 9
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h5555;
    set_raddr(5'd9, 5'd9, 5'd0, 5'd9);
    cycle();
    we0 = 1'b0; we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h1234;
    cycle();
    we1 = 1'b0;
    cycle();

    // Out-of-range writes and reads
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd30; waddr1 = 5'd24; wdata0 = 32'hBAD0; wdata1 = 32'hBAD1;
    set_raddr(5'd30, 5'd24, 5'd31, 5'd23);
    cycle();
    we0 = 1'b0; we1 = 1'b0;
    for (int b = 0; b < 32; b += 4) begin
      set_raddr(5'(b), 5'(b+1), 5'(b+2), 5'(b+3));
      cycle();
    end

    // Reset in the middle of the clear restarts the full sequence
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run_clear("clear_len_mid_reset");

    // Random traffic with occasional resets and address collisions
    repeat (1500) begin
      rst = ($urandom_range(0, 199) == 0);
      we0 = 1'($urandom); we1 = 1'($urandom);
      waddr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
      waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
      wdata1 = $urandom;
      set_raddr(waddr0, waddr1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (DEPTH + 2) cycle();
    for (int b = 0; b < 32; b += 4) begin
      set_raddr(5'(b), 5'(b+1), 5'(b+2), 5'(b+3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
